// File: rtl/storage_pkg.sv
// Shared definitions for the Morse storage block: symbol codes, default
// sequence width, word-separator constant, button indices and FSM states.
package storage_pkg;

  // Width of one stored sequence (5 symbols x 2 bits).
  localparam int SEQ_W_DEF = 10;

  // Symbol encoding inside a sequence.
  localparam int SYM_W = 2;
  typedef logic [SYM_W-1:0] sym_t;
  localparam sym_t SYM_EMPTY = 2'b00;
  localparam sym_t SYM_DOT   = 2'b01;
  localparam sym_t SYM_DASH  = 2'b10;
  localparam sym_t SYM_SPACE = 2'b11;

  // A word gap is stored as a sequence made entirely of space symbols.
  localparam logic [9:0] SEP_SEQ = 10'h3FF;

  // Bit positions of the pushbuttons in the internal button vector.
  localparam int NUM_BTN   = 6;
  localparam int BTN_DOT   = 0;
  localparam int BTN_DASH  = 1;
  localparam int BTN_SPACE = 2;
  localparam int BTN_END   = 3;
  localparam int BTN_CLEAR = 4;
  localparam int BTN_ENTER = 5;

  // Transmit FSM.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Number of symbol positions that fit in a sequence of the given width.
  function automatic int sym_count(input int seq_w);
    return seq_w / SYM_W;
  endfunction

endpackage

// File: rtl/storage_main_edge_pulse.sv
// edge_pulse: registers a pushbutton level and flags its rising edge.
// A button already held when reset is released stays disarmed until it has
// been seen low, so holding a key through reset never produces an action.
module edge_pulse (
  input  logic clk,
  input  logic srst,
  input  logic btn,
  output logic level,
  output logic pulse
);

  logic sample_q, sample_d;
  logic prev_q, prev_d;
  logic armed_q, armed_d;

  // Next values: sample the raw button, keep one older sample, arm on release.
  always_comb begin
    sample_d = btn;
    prev_d   = sample_q;
    armed_d  = armed_q | ~btn;
  end

  // Button sample registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      sample_q <= 1'b0;
      prev_q   <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      sample_q <= sample_d;
      prev_q   <= prev_d;
      armed_q  <= armed_d;
    end
  end

  assign level = sample_q;
  assign pulse = sample_q & ~prev_q & armed_q;

endmodule

// File: rtl/storage_main.sv
// storage_main: Morse keyer front end. Builds a sequence from Dot/Dash
// presses, commits finished sequences (and word separators) into a small
// slot store, and streams the store out one slot per cycle on Enter.
// Optional feature macro: STORAGE_BUZZER_EN (drives dot/dash buzzer outputs;
// when undefined both buzzers are held at 0).
module storage_main
  import storage_pkg::*;
#(
  parameter int SEQ_W = SEQ_W_DEF,
  parameter int DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic                   Dot,
  input  logic                   Dash,
  input  logic                   Space,
  input  logic                   EndSeq,
  input  logic                   Clear,
  input  logic                   Enter,
  output logic                   dot_buzzer,
  output logic                   dash_buzzer,
  output logic                   spa_end,
  output logic                   sent,
  output logic                   sentSeparator,
  output logic [SEQ_W-1:0]       FirstSeq,
  output logic [SEQ_W-1:0]       SecSeq,
  output logic [SEQ_W-1:0]       o_sequence,
  output logic                   storageSent,
  output logic [SEQ_W*DEPTH-1:0] store_seqs
);

  localparam int NSYM   = sym_count(SEQ_W);
  localparam int CNT_W  = $clog2(NSYM + 1);
  localparam int USED_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  NSYM_C  = CNT_W'(NSYM);
  localparam logic [USED_W-1:0] DEPTH_C = USED_W'(DEPTH);
  localparam logic [SEQ_W-1:0]  SEP_C   = SEQ_W'(SEP_SEQ);

  // ---------------------------------------------------------------------
  // Button registration and edge detection
  // ---------------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_vec;
  logic [NUM_BTN-1:0] lvl_vec;
  logic [NUM_BTN-1:0] edge_vec;
  logic               unused_lvl;

  assign btn_vec = {Enter, Clear, EndSeq, Space, Dash, Dot};

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      edge_pulse u_edge (
        .clk   (clk),
        .srst  (Reset),
        .btn   (btn_vec[gi]),
        .level (lvl_vec[gi]),
        .pulse (edge_vec[gi])
      );
    end
  endgenerate

`ifdef STORAGE_BUZZER_EN
  assign dot_buzzer  = lvl_vec[BTN_DOT];
  assign dash_buzzer = lvl_vec[BTN_DASH];
  assign unused_lvl  = ^lvl_vec[NUM_BTN-1:BTN_SPACE];
`else
  assign dot_buzzer  = 1'b0;
  assign dash_buzzer = 1'b0;
  assign unused_lvl  = ^lvl_vec;
`endif

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e                   state_q, state_d;
  logic [USED_W-1:0]        idx_q, idx_d;
  logic [USED_W-1:0]        used_q, used_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SEQ_W-1:0]         first_q, first_d;
  logic [SEQ_W-1:0]         sec_q, sec_d;
  logic [SEQ_W*DEPTH-1:0]   store_q, store_d;
  logic                     spa_end_q, spa_end_d;
  logic                     sent_q, sent_d;
  logic                     sep_q, sep_d;

  logic in_idle;
  logic send_done;
  logic end_ok;
  logic spc_ok;

  assign in_idle   = (state_q == ST_IDLE);
  assign send_done = (state_q == ST_SEND) && (idx_q == used_q - 1'b1);
  // Commits and new transmissions are only accepted while idle.
  assign end_ok    = edge_vec[BTN_END] & in_idle;
  assign spc_ok    = edge_vec[BTN_SPACE] & in_idle;

  // FSM state register plus transmit index.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // FSM next state: start on Enter with a non-empty store, walk the used slots.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (edge_vec[BTN_ENTER] && (used_q != '0)) begin
          state_d = ST_SEND;
          idx_d   = '0;
        end
      end
      ST_SEND: begin
        if (send_done) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // FSM outputs: present the current slot while sending, zero otherwise.
  always_comb begin
    o_sequence  = '0;
    storageSent = 1'b0;
    if (state_q == ST_SEND) begin
      o_sequence  = store_q[idx_q*SEQ_W +: SEQ_W];
      storageSent = 1'b1;
    end
  end

  // Sequence builder and store: one prioritised button action per cycle.
  always_comb begin
    logic [USED_W-1:0] wr_used;
    first_d   = first_q;
    cnt_d     = cnt_q;
    sec_d     = sec_q;
    store_d   = store_q;
    used_d    = used_q;
    spa_end_d = 1'b0;
    sent_d    = 1'b0;
    sep_d     = 1'b0;
    wr_used   = used_q;

    if (edge_vec[BTN_CLEAR]) begin
      first_d = '0;
      cnt_d   = '0;
    end else if (end_ok) begin
      // An empty sequence is not a commit and produces no pulses.
      if (first_q != '0) begin
        spa_end_d = 1'b1;
        if (wr_used < DEPTH_C) begin
          store_d[wr_used*SEQ_W +: SEQ_W] = first_q;
          sec_d   = first_q;
          sent_d  = 1'b1;
          wr_used = wr_used + 1'b1;
        end
        first_d = '0;
        cnt_d   = '0;
      end
    end else if (spc_ok) begin
      // Flush any pending letter first, then the word separator behind it.
      spa_end_d = 1'b1;
      if (first_q != '0) begin
        if (wr_used < DEPTH_C) begin
          store_d[wr_used*SEQ_W +: SEQ_W] = first_q;
          sec_d   = first_q;
          sent_d  = 1'b1;
          wr_used = wr_used + 1'b1;
        end
        first_d = '0;
        cnt_d   = '0;
      end
      if (wr_used < DEPTH_C) begin
        store_d[wr_used*SEQ_W +: SEQ_W] = SEP_C;
        sep_d   = 1'b1;
        wr_used = wr_used + 1'b1;
      end
    end else if (edge_vec[BTN_DOT]) begin
      if (cnt_q < NSYM_C) begin
        first_d[cnt_q*SYM_W +: SYM_W] = SYM_DOT;
        cnt_d = cnt_q + 1'b1;
      end
    end else if (edge_vec[BTN_DASH]) begin
      if (cnt_q < NSYM_C) begin
        first_d[cnt_q*SYM_W +: SYM_W] = SYM_DASH;
        cnt_d = cnt_q + 1'b1;
      end
    end

    used_d = wr_used;

    // The last transmitted slot empties the whole store.
    if (send_done) begin
      store_d = '0;
      used_d  = '0;
    end
  end

  // Datapath registers and output pulses.
  always_ff @(posedge clk) begin
    if (Reset) begin
      first_q   <= '0;
      cnt_q     <= '0;
      sec_q     <= '0;
      store_q   <= '0;
      used_q    <= '0;
      spa_end_q <= 1'b0;
      sent_q    <= 1'b0;
      sep_q     <= 1'b0;
    end else begin
      first_q   <= first_d;
      cnt_q     <= cnt_d;
      sec_q     <= sec_d;
      store_q   <= store_d;
      used_q    <= used_d;
      spa_end_q <= spa_end_d;
      sent_q    <= sent_d;
      sep_q     <= sep_d;
    end
  end

  assign FirstSeq      = first_q;
  assign SecSeq        = sec_q;
  assign store_seqs    = store_q;
  assign spa_end       = spa_end_q;
  assign sent          = sent_q;
  assign sentSeparator = sep_q;

endmodule

// File: tb/tb_storage_main.sv
// Directed bench for storage_main with a scoreboard for transmitted slots.
module tb_storage_main;

  localparam logic [5:0] B_DOT  = 6'b000001;
  localparam logic [5:0] B_DASH = 6'b000010;
  localparam logic [5:0] B_SPC  = 6'b000100;
  localparam logic [5:0] B_END  = 6'b001000;
  localparam logic [5:0] B_CLR  = 6'b010000;
  localparam logic [5:0] B_ENT  = 6'b100000;

`ifdef STORAGE_BUZZER_EN
  localparam logic BUZ_EXP = 1'b1;
`else
  localparam logic BUZ_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        Reset, Dot, Dash, Space, EndSeq, Clear, Enter;
  logic        dot_buzzer, dash_buzzer, spa_end, sent, sentSeparator, storageSent;
  logic [9:0]  FirstSeq, SecSeq, o_sequence;
  logic [29:0] store_seqs;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int sent_cnt = 0;
  int sep_cnt = 0;
  int spa_cnt = 0;
  int ss_cnt = 0;
  logic [9:0] sb[$];

  always #5 clk = ~clk;

  storage_main dut (
    .clk           (clk),
    .Reset         (Reset),
    .Dot           (Dot),
    .Dash          (Dash),
    .Space         (Space),
    .EndSeq        (EndSeq),
    .Clear         (Clear),
    .Enter         (Enter),
    .dot_buzzer    (dot_buzzer),
    .dash_buzzer   (dash_buzzer),
    .spa_end       (spa_end),
    .sent          (sent),
    .sentSeparator (sentSeparator),
    .FirstSeq      (FirstSeq),
    .SecSeq        (SecSeq),
    .o_sequence    (o_sequence),
    .storageSent   (storageSent),
    .store_seqs    (store_seqs)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // One press: high for one cycle, then released; returns after the action
  // has landed and its pulses are visible.
  task automatic press(input logic [5:0] m);
    @(negedge clk);
    {Enter, Clear, EndSeq, Space, Dash, Dot} = m;
    @(negedge clk);
    {Enter, Clear, EndSeq, Space, Dash, Dot} = '0;
    @(negedge clk);
    #1;
  endtask

  task automatic press_n(input logic [5:0] m, input int n);
    for (int i = 0; i < n; i++) press(m);
  endtask

  // Wait (bounded) for the scoreboard to drain, then let the store clear.
  task automatic wait_drain(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk(tag, 64'(sb.size()), 64'd0);
    sb.delete();
    cyc(1);
  endtask

  // Monitor: count pulses, compare each transmitted slot to the scoreboard.
  always @(negedge clk) begin
    if (sent) sent_cnt++;
    if (sentSeparator) sep_cnt++;
    if (spa_end) spa_cnt++;
    if (storageSent) begin
      ss_cnt++;
      if (sb.size() == 0) begin
        chk("sb_unexpected_send", 64'(storageSent), 64'd0);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        $display("send slot o_sequence=%03h expected=%03h", o_sequence, e);
        chk("sb_o_sequence", 64'(o_sequence), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    int s0, p0, ss0, e0;
    {Enter, Clear, EndSeq, Space, Dash, Dot} = '0;
    Reset = 1'b1;
    cyc(3);
    Reset = 1'b0;
    cyc(1);

    // Reset state
    chk("rst_outputs", 64'({dot_buzzer, dash_buzzer, spa_end, sent, sentSeparator,
                            storageSent, FirstSeq, SecSeq, o_sequence}), 64'd0);
    chk("rst_store", 64'(store_seqs), 64'd0);

    // Three letters: S, O, S
    s0 = sent_cnt; p0 = spa_cnt;
    press_n(B_DOT, 3);
    chk("first_dots", 64'(FirstSeq), 64'h015);
    press(B_END);
    chk("first_cleared", 64'(FirstSeq), 64'h000);
    press_n(B_DASH, 3);
    press(B_END);
    press_n(B_DOT, 3);
    press(B_END);
    $display("sos store_seqs=%08h SecSeq=%03h", store_seqs, SecSeq);
    chk("sos_store", 64'(store_seqs), 64'h0150A815);
    chk("sos_secseq", 64'(SecSeq), 64'h015);
    chk("sos_sent_cnt", 64'(sent_cnt - s0), 64'd3);
    chk("sos_spa_cnt", 64'(spa_cnt - p0), 64'd3);

    // Transmit
    sb.push_back(10'h015); sb.push_back(10'h02A); sb.push_back(10'h015);
    press(B_ENT);
    wait_drain("sos_drain");
    chk("sos_store_after", 64'(store_seqs), 64'd0);
    chk("sos_idle_after", 64'({storageSent, o_sequence}), 64'd0);

    // Three letters: O, S, O
    press_n(B_DASH, 3); press(B_END);
    press_n(B_DOT, 3);  press(B_END);
    press_n(B_DASH, 3); press(B_END);
    chk("oso_store", 64'(store_seqs), 64'h02A0542A);
    sb.push_back(10'h02A); sb.push_back(10'h015); sb.push_back(10'h02A);
    press(B_ENT);
    wait_drain("oso_drain");
    chk("oso_store_after", 64'(store_seqs), 64'd0);

    // Full store: a fourth commit is dropped
    press(B_DOT); press(B_END);
    press(B_DASH); press(B_END);
    press(B_DOT); press(B_DASH); press(B_END);
    chk("full_store", 64'(store_seqs), 64'h00900801);
    s0 = sent_cnt;
    press(B_DASH); press(B_END);
    chk("full_store_kept", 64'(store_seqs), 64'h00900801);
    chk("full_no_sent", 64'(sent_cnt - s0), 64'd0);
    chk("full_first_cleared", 64'(FirstSeq), 64'd0);
    press_n(B_DOT, 6);
    chk("six_dots", 64'(FirstSeq), 64'h155);

    // Reset in the middle of a transmission
    sb.push_back(10'h001); sb.push_back(10'h002); sb.push_back(10'h009);
    press(B_ENT);
    chk("midsend_first_slot", 64'(sb.size()), 64'd2);
    Reset = 1'b1;
    cyc(1);
    sb.delete();
    chk("midsend_rst_outputs", 64'({spa_end, sent, sentSeparator, storageSent,
                                    FirstSeq, SecSeq, o_sequence}), 64'd0);
    chk("midsend_rst_store", 64'(store_seqs), 64'd0);
    cyc(1);
    Reset = 1'b0;
    cyc(1);
    ss0 = ss_cnt;
    press(B_ENT);
    cyc(5);
    chk("empty_enter", 64'(ss_cnt - ss0), 64'd0);

    // Button held through reset release produces no action
    @(negedge clk);
    Reset = 1'b1; Dot = 1'b1;
    cyc(2);
    Reset = 1'b0;
    cyc(4);
    chk("hold_no_edge", 64'(FirstSeq), 64'd0);
    chk("hold_dot_buzzer", 64'(dot_buzzer), 64'(BUZ_EXP));
    chk("hold_dash_buzzer", 64'(dash_buzzer), 64'd0);
    Dot = 1'b0;
    cyc(2);
    press(B_DOT);
    chk("repress_dot", 64'(FirstSeq), 64'h001);

    // Space commits the letter and then a separator
    s0 = sent_cnt; e0 = sep_cnt;
    press(B_SPC);
    chk("space_store", 64'(store_seqs), 64'h000FFC01);
    chk("space_sep_cnt", 64'(sep_cnt - e0), 64'd1);
    chk("space_sent_cnt", 64'(sent_cnt - s0), 64'd1);

    // Clear drops only the in-progress letter
    press(B_DASH);
    chk("dash_first", 64'(FirstSeq), 64'h002);
    press(B_CLR);
    chk("clear_first", 64'(FirstSeq), 64'd0);
    chk("clear_store_kept", 64'(store_seqs), 64'h000FFC01);
    chk("clear_secseq_kept", 64'(SecSeq), 64'h001);

    // EndSeq with nothing pending is ignored
    s0 = sent_cnt; p0 = spa_cnt;
    press(B_END);
    chk("empty_end_sent", 64'(sent_cnt - s0), 64'd0);
    chk("empty_end_spa", 64'(spa_cnt - p0), 64'd0);

    // Same-cycle priority
    press(B_DOT | B_DASH);
    chk("prio_dot_over_dash", 64'(FirstSeq), 64'h001);
    press(B_CLR | B_DOT);
    chk("prio_clear_over_dot", 64'(FirstSeq), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
